// File: rtl/core_wb_pkg.sv
// Purpose: shared write-back encodings (mux select, load funct3 codes) for the MEM/WB slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   wb_sel_e        write-back mux select: WB_ALU=00, WB_LOAD=01, WB_PC4=10, WB_IMM=11
//   F3_*            load funct3 codes (LB, LH, LW, LBU, LHU)
//   is_misaligned() misaligned-load predicate used when MEM_WB_MISALIGN_CHECK_EN is defined
package core_wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_IMM  = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Halfwords must sit on an even byte, words on offset 0; byte loads are always aligned.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if ((funct3 == F3_LH) || (funct3 == F3_LHU)) begin
            mis = off[0];
        end else if (funct3 == F3_LW) begin
            mis = (off != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// Purpose: extract and sign/zero-extend the addressed byte/halfword/word of a raw memory word.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   word    in   XLEN  raw word from data memory
//   off     in   2     byte offset within the word (address bits [1:0])
//   funct3  in   3     load type; unknown codes yield 0
//   result  out  XLEN  aligned, extended load data
module load_align
    import core_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Halfword choice uses only off[1]; an odd offset is the misalign checker's concern, not ours.
    always_comb begin
        sel_byte = 8'h00;
        case (off)
            2'd0: sel_byte = word[7:0];
            2'd1: sel_byte = word[15:8];
            2'd2: sel_byte = word[23:16];
            2'd3: sel_byte = word[31:24];
            default: sel_byte = 8'h00;
        endcase
        sel_half = off[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = '0;
        case (funct3)
            F3_LB:  result = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            F3_LH:  result = {{(XLEN-16){sel_half[15]}}, sel_half};
            F3_LW:  result = word;
            F3_LBU: result = {{(XLEN-8){1'b0}}, sel_byte};
            F3_LHU: result = {{(XLEN-16){1'b0}}, sel_half};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Purpose: MEM/WB pipeline register feeding the 4:1 write-back mux (ALU, load, PC+4, imm).
// Latency: 1 cycle, registered outputs only; no input->output combinational path.
// Backpressure: stall_i holds every output; flush_i inserts a bubble (all zeros), and wins over stall.
//
// Ports:
//   clk_i, rst_i                clock and synchronous active-high reset
//   stall_i, flush_i            hold / bubble controls (priority rst > flush > stall > capture)
//   valid_i, reg_write_i        instruction valid and rd write request from MEM
//   alu_result_i, load_data_i   ALU result (bits [1:0] = load byte offset) and raw memory word
//   pc_plus4_i, imm_i           remaining write-back candidates
//   funct3_i, wb_sel_i          load type and write-back source select
//   rd_addr_i                   destination register
//   wb_alu_o..wb_imm_o          registered mux inputs (sel 00..11)
//   wb_sel_o, rd_addr_o         registered mux select and register-file address
//   reg_write_o, valid_o        registered write enable (gated) and valid
//   misalign_o                  registered misaligned-load flag
//
// Build option: MEM_WB_MISALIGN_CHECK_EN enables misaligned-load detection; when undefined
// misalign_o is tied to 0 and loads align using the truncated offset.
module mem_wb_stage
    import core_wb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [XLEN-1:0]       alu_result_i,
    input  logic [XLEN-1:0]       load_data_i,
    input  logic [XLEN-1:0]       pc_plus4_i,
    input  logic [XLEN-1:0]       imm_i,
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            wb_sel_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  reg_write_i,
    output logic [XLEN-1:0]       wb_alu_o,
    output logic [XLEN-1:0]       wb_load_o,
    output logic [XLEN-1:0]       wb_pc4_o,
    output logic [XLEN-1:0]       wb_imm_o,
    output logic [1:0]            wb_sel_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  reg_write_o,
    output logic                  valid_o,
    output logic                  misalign_o
);

    logic [XLEN-1:0] load_aligned;
    logic            misalign_d;
    logic            reg_write_d;

    // Alignment runs for every instruction; the result is simply ignored unless wb_sel=WB_LOAD.
    load_align #(.XLEN(XLEN)) u_load_align (
        .word   (load_data_i),
        .off    (alu_result_i[1:0]),
        .funct3 (funct3_i),
        .result (load_aligned)
    );

`ifdef MEM_WB_MISALIGN_CHECK_EN
    assign misalign_d = (wb_sel_i == WB_LOAD) && is_misaligned(funct3_i, alu_result_i[1:0]);
`else
    assign misalign_d = 1'b0;
`endif

    // x0 is hard-wired zero, so a write to it is dropped here rather than in the register file.
    assign reg_write_d = reg_write_i & valid_i & (rd_addr_i != '0) & ~misalign_d;

    logic misalign_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wb_alu_o    <= '0;
            wb_load_o   <= '0;
            wb_pc4_o    <= '0;
            wb_imm_o    <= '0;
            wb_sel_o    <= WB_ALU;
            rd_addr_o   <= '0;
            reg_write_o <= 1'b0;
            valid_o     <= 1'b0;
            misalign_q  <= 1'b0;
        end else if (!stall_i) begin
            wb_alu_o    <= alu_result_i;
            wb_load_o   <= load_aligned;
            wb_pc4_o    <= pc_plus4_i;
            wb_imm_o    <= imm_i;
            wb_sel_o    <= wb_sel_i;
            rd_addr_o   <= rd_addr_i;
            reg_write_o <= reg_write_d;
            valid_o     <= valid_i;
            misalign_q  <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Purpose: randomized scoreboard bench for mem_wb_stage against a behavioural reference model.
// Latency: expects every output one edge after the inputs are driven.
// Backpressure: exercises stall/flush/reset priority with directed and random stimulus.
module tb_mem_wb_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] load;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        we;
        logic        vld;
        logic        mis;
    } exp_t;

    logic        clk;
    logic        rst_i, stall_i, flush_i, valid_i, reg_write_i;
    logic [31:0] alu_result_i, load_data_i, pc_plus4_i, imm_i;
    logic [2:0]  funct3_i;
    logic [1:0]  wb_sel_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] wb_alu_o, wb_load_o, wb_pc4_o, wb_imm_o;
    logic [1:0]  wb_sel_o;
    logic [4:0]  rd_addr_o;
    logic        reg_write_o, valid_o, misalign_o;

    mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .alu_result_i (alu_result_i),
        .load_data_i  (load_data_i),
        .pc_plus4_i   (pc_plus4_i),
        .imm_i        (imm_i),
        .funct3_i     (funct3_i),
        .wb_sel_i     (wb_sel_i),
        .rd_addr_i    (rd_addr_i),
        .reg_write_i  (reg_write_i),
        .wb_alu_o     (wb_alu_o),
        .wb_load_o    (wb_load_o),
        .wb_pc4_o     (wb_pc4_o),
        .wb_imm_o     (wb_imm_o),
        .wb_sel_o     (wb_sel_o),
        .rd_addr_o    (rd_addr_o),
        .reg_write_o  (reg_write_o),
        .valid_o      (valid_o),
        .misalign_o   (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t model;
    int   vectors;
    int   miscompares;
    bit   check_en;

`ifdef MEM_WB_MISALIGN_CHECK_EN
    initial check_en = 1'b1;
`else
    initial check_en = 1'b0;
`endif

    // Reference load alignment: shift the word down by the byte offset and extend arithmetically.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input int f3);
        longint v;
        case (f3)
            0: begin v = (w >> (8 * off)) & 32'hFF;            if (v >= 128)   v = v - 256;   end
            1: begin v = (w >> (16 * (off / 2))) & 32'hFFFF;   if (v >= 32768) v = v - 65536; end
            2: v = w;
            4: v = (w >> (8 * off)) & 32'hFF;
            5: v = (w >> (16 * (off / 2))) & 32'hFFFF;
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    function automatic bit ref_misalign(input int sel, input int f3, input int off);
        if (!check_en || sel != 1) return 1'b0;
        if (f3 == 1 || f3 == 5) return (off % 2) != 0;
        if (f3 == 2) return off != 0;
        return 1'b0;
    endfunction

    // Drive one cycle of inputs on the falling edge and queue the value expected after the next rising edge.
    task automatic apply(input bit rst, input bit flush, input bit stall, input bit vld,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc4,
                         input logic [31:0] imm, input int f3, input int sel, input int rd,
                         input bit we);
        exp_t nxt;
        bit   mis;
        @(negedge clk);
        rst_i = rst; flush_i = flush; stall_i = stall; valid_i = vld;
        alu_result_i = alu; load_data_i = ld; pc_plus4_i = pc4; imm_i = imm;
        funct3_i = 3'(f3); wb_sel_i = 2'(sel); rd_addr_i = 5'(rd); reg_write_i = we;
        if (rst || flush) begin
            nxt = '0;
        end else if (stall) begin
            nxt = model;
        end else begin
            mis      = ref_misalign(sel, f3, int'(alu % 4));
            nxt.alu  = alu;
            nxt.load = ref_load(ld, int'(alu % 4), f3);
            nxt.pc4  = pc4;
            nxt.imm  = imm;
            nxt.sel  = 2'(sel);
            nxt.rd   = 5'(rd);
            nxt.we   = we && vld && (rd != 0) && !mis;
            nxt.vld  = vld;
            nxt.mis  = mis;
        end
        model = nxt;
        sb.push_back(nxt);
    endtask

    // Monitor: outputs are present every cycle, so compare one queued expectation per rising edge.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a.alu = wb_alu_o;  a.load = wb_load_o; a.pc4 = wb_pc4_o; a.imm = wb_imm_o;
                a.sel = wb_sel_o;  a.rd = rd_addr_o;   a.we = reg_write_o;
                a.vld = valid_o;   a.mis = misalign_o;
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL stage_out t=%0t got alu=%h ld=%h pc4=%h imm=%h sel=%0d rd=%0d we=%b v=%b mis=%b | want alu=%h ld=%h pc4=%h imm=%h sel=%0d rd=%0d we=%b v=%b mis=%b",
                             $time, a.alu, a.load, a.pc4, a.imm, a.sel, a.rd, a.we, a.vld, a.mis,
                             e.alu, e.load, e.pc4, e.imm, e.sel, e.rd, e.we, e.vld, e.mis);
                end
            end
        end
    end

    initial begin
        vectors = 0; miscompares = 0; model = '0;
        rst_i = 1'b1; flush_i = 1'b0; stall_i = 1'b0; valid_i = 1'b0;
        alu_result_i = '0; load_data_i = '0; pc_plus4_i = '0; imm_i = '0;
        funct3_i = '0; wb_sel_i = '0; rd_addr_i = '0; reg_write_i = 1'b0;

        // Reset with busy inputs clears everything.
        apply(1, 0, 0, 1, 32'hDEAD_BEEF, 32'h1234_5678, 32'h40, 32'h7000, 2, 3, 9, 1);
        apply(1, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h44, 32'h1, 0, 1, 31, 1);
        // LB of top byte, negative.
        apply(0, 0, 0, 1, 32'h0000_0003, 32'h80FF_7F01, 32'h104, 32'h0, 0, 1, 5, 1);
        // LHU / LH of upper half.
        apply(0, 0, 0, 1, 32'h0000_0002, 32'h8001_1234, 32'h108, 32'h0, 5, 1, 6, 1);
        apply(0, 0, 0, 1, 32'h0000_0002, 32'h8001_1234, 32'h10C, 32'h0, 1, 1, 6, 1);
        // LBU of byte 1 and an undefined funct3.
        apply(0, 0, 0, 1, 32'h0000_0001, 32'h80FF_7F01, 32'h110, 32'h0, 4, 1, 8, 1);
        apply(0, 0, 0, 1, 32'h0000_0000, 32'h80FF_7F01, 32'h114, 32'h0, 3, 1, 8, 1);
        // Capture, stall three cycles with moving inputs, then stall+flush.
        apply(0, 0, 0, 1, 32'h0000_1234, 32'hAAAA_5555, 32'h118, 32'h5000, 2, 0, 10, 1);
        for (int i = 0; i < 3; i++)
            apply(0, 0, 1, i[0], $urandom, $urandom, $urandom, $urandom, 2, 2, 11 + i, 1);
        apply(0, 1, 1, 1, 32'h9999, 32'h8888, 32'h7777, 32'h6666, 0, 3, 12, 1);
        // Write gating on x0 and on invalid instructions.
        apply(0, 0, 0, 1, 32'h10, 32'h0, 32'h11C, 32'h0, 2, 0, 0, 1);
        apply(0, 0, 0, 0, 32'h14, 32'h0, 32'h120, 32'h0, 2, 0, 7, 1);
        // LW at offset 2, then LH at offset 1, both through the load path.
        apply(0, 0, 0, 1, 32'h0000_0102, 32'hCAFE_F00D, 32'h124, 32'h0, 2, 1, 9, 1);
        apply(0, 0, 0, 1, 32'h0000_0101, 32'hCAFE_F00D, 32'h128, 32'h0, 1, 1, 9, 1);
        // Same misaligned LW but not selecting load: no flag.
        apply(0, 0, 0, 1, 32'h0000_0102, 32'hCAFE_F00D, 32'h12C, 32'h0, 2, 0, 9, 1);

        // Random traffic with mixed control.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            apply(r < 2, (r >= 2 && r < 10), ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 80), $urandom, $urandom, $urandom, $urandom,
                  $urandom_range(0, 7), $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 31), $urandom_range(0, 1));
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
